// File: rtl/cpc_mem_responder.sv
// rtl/cpc_mem_responder.sv - memory bus responder: CPU byte access and video word fetch over one 8-bit RAM
// Video fetches win arbitration; RAM strobes are registered from the next-state decode.
module cpc_mem_responder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [22:0] mem_addr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  input  logic        vid_req,
  input  logic [14:0] vram_addr,
  output logic [15:0] vram_din,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [22:0] ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        vid_overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_VID0, S_VID1, S_VIDC, S_CRD0, S_CRD1, S_CWR
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_mem_rd_q;
  logic        r_mem_wr_q;
  logic        r_cpu_pend;
  logic        r_cpu_wr;
  logic [22:0] r_cpu_addr;
  logic [7:0]  r_cpu_data;
  logic        r_vid_pend;
  logic [14:0] r_vid_addr;
  logic        r_vid_overrun;
  logic [7:0]  r_hi_byte;
  logic [7:0]  r_cpu_din;
  logic [15:0] r_vram_din;
  logic        r_ram_ce;
  logic        r_ram_we;
  logic [22:0] r_ram_addr;
  logic [7:0]  r_ram_wdata;

  logic        w_rd_rise;
  logic        w_wr_rise;
  logic        w_cpu_capture;
  logic        w_vid_busy;
  logic        w_ce_nxt;
  logic        w_we_nxt;
  logic [22:0] w_addr_nxt;

  assign w_rd_rise     = mem_rd & ~r_mem_rd_q;
  assign w_wr_rise     = mem_wr & ~r_mem_wr_q;
  assign w_cpu_capture = ~r_cpu_pend & (w_rd_rise | w_wr_rise);
  assign w_vid_busy    = r_vid_pend | (r_state == S_VID0) | (r_state == S_VID1) | (r_state == S_VIDC);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      // VIDC re-arbitrates directly so back-to-back service has no idle bubble
      S_IDLE, S_VIDC: begin
        if (r_vid_pend)                  w_state_nxt = S_VID0;
        else if (r_cpu_pend && r_cpu_wr) w_state_nxt = S_CWR;
        else if (r_cpu_pend)             w_state_nxt = S_CRD0;
        else                             w_state_nxt = S_IDLE;
      end
      S_VID0:  w_state_nxt = S_VID1;
      S_VID1:  w_state_nxt = S_VIDC;
      S_CRD0:  w_state_nxt = S_CRD1;
      S_CRD1:  w_state_nxt = S_IDLE;
      S_CWR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ce_nxt   = 1'b0;
    w_we_nxt   = 1'b0;
    w_addr_nxt = r_ram_addr;
    case (w_state_nxt)
      S_VID0: begin
        w_ce_nxt   = 1'b1;
        w_addr_nxt = {7'b0, r_vid_addr, 1'b0};
      end
      S_VID1: begin
        w_ce_nxt   = 1'b1;
        w_addr_nxt = {7'b0, r_vid_addr, 1'b1};
      end
      S_CRD0: begin
        w_ce_nxt   = 1'b1;
        w_addr_nxt = r_cpu_addr;
      end
      S_CWR: begin
        w_ce_nxt   = 1'b1;
        w_we_nxt   = 1'b1;
        w_addr_nxt = r_cpu_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_rd_q <= 1'b0;
      r_mem_wr_q <= 1'b0;
      r_cpu_pend <= 1'b0;
      r_cpu_wr   <= 1'b0;
      r_cpu_addr <= '0;
      r_cpu_data <= '0;
    end else begin
      r_mem_rd_q <= mem_rd;
      r_mem_wr_q <= mem_wr;
      if (w_cpu_capture) begin
        r_cpu_pend <= 1'b1;
        r_cpu_wr   <= w_wr_rise;
        r_cpu_addr <= mem_addr;
        r_cpu_data <= cpu_dout;
      end else if (r_state == S_CRD1 || r_state == S_CWR) begin
        r_cpu_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vid_pend    <= 1'b0;
      r_vid_addr    <= '0;
      r_vid_overrun <= 1'b0;
    end else begin
      if (vid_req && w_vid_busy) begin
        r_vid_overrun <= 1'b1;
      end
      if (vid_req && !w_vid_busy) begin
        r_vid_pend <= 1'b1;
        r_vid_addr <= vram_addr;
      end else if (r_state == S_VID0) begin
        r_vid_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi_byte  <= '0;
      r_cpu_din  <= 8'hFF;
      r_vram_din <= '0;
    end else begin
      if (r_state == S_VID1) r_hi_byte  <= ram_rdata;
      if (r_state == S_VIDC) r_vram_din <= {r_hi_byte, ram_rdata};
      if (r_state == S_CRD1) r_cpu_din  <= ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ram_ce    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_ram_ce   <= w_ce_nxt;
      r_ram_we   <= w_we_nxt;
      r_ram_addr <= w_addr_nxt;
      if (w_state_nxt == S_CWR) r_ram_wdata <= r_cpu_data;
    end
  end

  assign cpu_din     = r_cpu_din;
  assign vram_din    = r_vram_din;
  assign ram_ce      = r_ram_ce;
  assign ram_we      = r_ram_we;
  assign ram_addr    = r_ram_addr;
  assign ram_wdata   = r_ram_wdata;
  assign vid_overrun = r_vid_overrun;

endmodule
